// File: rtl/ixu_sc_issue_queue.sv
// Issue queue for the IXU single-cycle pipe.
// A collapsing queue with entry 0 as the oldest. Each cycle it issues the
// oldest entry whose two sources are ready as a registered {rs2, rs1, rob}
// packet. Wakeup tags from the pipe itself and from one external port set
// the source ready bits. They are also bypassed into the same-cycle select.
module ixu_sc_issue_queue #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          core_clock_i,
    input  logic          core_reset_i,
    input  logic          core_flush_i,
    input  logic          enq_valid_i,
    input  logic [5:0]    enq_rob_i,
    input  logic [5:0]    enq_rs1_i,
    input  logic          enq_rs1_rdy_i,
    input  logic [5:0]    enq_rs2_i,
    input  logic          enq_rs2_rdy_i,
    output logic          enq_ready_o,
    input  logic [5:0]    wakeup_dest_i,
    input  logic          wakeup_valid_i,
    input  logic [5:0]    ext_wakeup_dest_i,
    input  logic          ext_wakeup_valid_i,
    output logic [17:0]   data_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    typedef struct packed {
        logic [5:0] rob;
        logic [5:0] rs1;
        logic       rs1_rdy;
        logic [5:0] rs2;
        logic       rs2_rdy;
    } entry_t;

    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    entry_t          enq_ent;
    logic [CW-1:0]   count_q, count_d, enq_pos;
    logic [17:0]     data_q, sel_pkt;
    logic            valid_q;
    logic            issue_en;
    logic            enq_fire;
    logic [DEPTH-1:0] elig;
    logic [DEPTH-1:0] shift;

    // A tag is woken when either valid wakeup port carries it. Physical
    // register 0 is never a wakeup target.
    function automatic logic woken(input logic [5:0] tag,
                                   input logic [5:0] w_tag, input logic w_vld,
                                   input logic [5:0] e_tag, input logic e_vld);
        return (tag != 6'd0) && ((w_vld && (w_tag == tag)) || (e_vld && (e_tag == tag)));
    endfunction

    // A source is usable now if it is stored ready, if it is p0, or if it is woken this cycle.
    function automatic logic src_ready(input logic [5:0] tag, input logic rdy,
                                       input logic [5:0] w_tag, input logic w_vld,
                                       input logic [5:0] e_tag, input logic e_vld);
        return rdy || (tag == 6'd0) || woken(tag, w_tag, w_vld, e_tag, e_vld);
    endfunction

    // Readiness is taken from registered occupancy only. A same-cycle issue does not count.
    assign enq_ready_o = (count_q < CW'(DEPTH));
    assign enq_fire    = enq_valid_i && enq_ready_o;

    // Oldest-first select with the wakeup bypass. shift[i] marks the slots at and above the winner.
    always_comb begin
        issue_en = 1'b0;
        sel_pkt  = '0;
        elig     = '0;
        shift    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = (CW'(i) < count_q)
                && src_ready(ent_q[i].rs1, ent_q[i].rs1_rdy, wakeup_dest_i, wakeup_valid_i,
                             ext_wakeup_dest_i, ext_wakeup_valid_i)
                && src_ready(ent_q[i].rs2, ent_q[i].rs2_rdy, wakeup_dest_i, wakeup_valid_i,
                             ext_wakeup_dest_i, ext_wakeup_valid_i);
            if (elig[i] && !issue_en) begin
                issue_en = 1'b1;
                sel_pkt  = {ent_q[i].rs2, ent_q[i].rs1, ent_q[i].rob};
            end
            shift[i] = issue_en;
        end
    end

    // Next entry array: collapse over the issued slot, apply the wakeups, then place the new entry.
    always_comb begin
        enq_ent.rob     = enq_rob_i;
        enq_ent.rs1     = enq_rs1_i;
        enq_ent.rs1_rdy = src_ready(enq_rs1_i, enq_rs1_rdy_i, wakeup_dest_i, wakeup_valid_i,
                                    ext_wakeup_dest_i, ext_wakeup_valid_i);
        enq_ent.rs2     = enq_rs2_i;
        enq_ent.rs2_rdy = src_ready(enq_rs2_i, enq_rs2_rdy_i, wakeup_dest_i, wakeup_valid_i,
                                    ext_wakeup_dest_i, ext_wakeup_valid_i);
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (shift[i]) begin
                ent_d[i] = ent_q[i + 1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i].rs1_rdy = ent_d[i].rs1_rdy | woken(ent_d[i].rs1, wakeup_dest_i, wakeup_valid_i,
                                                        ext_wakeup_dest_i, ext_wakeup_valid_i);
            ent_d[i].rs2_rdy = ent_d[i].rs2_rdy | woken(ent_d[i].rs2, wakeup_dest_i, wakeup_valid_i,
                                                        ext_wakeup_dest_i, ext_wakeup_valid_i);
        end
        enq_pos = count_q - CW'(issue_en);
        for (int i = 0; i < DEPTH; i++) begin
            if (enq_fire && (CW'(i) == enq_pos)) begin
                ent_d[i] = enq_ent;
            end
        end
        count_d = count_q + CW'(enq_fire) - CW'(issue_en);
    end

    // Entry payload storage.
    // NOTE: the entry array is not reset. count_q alone decides which slots are live,
    // so clearing count on reset or flush is enough to empty the queue.
    always_ff @(posedge core_clock_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
        end
    end

    // Occupancy and the issue register. Flush takes priority over enqueue and issue.
    always_ff @(posedge core_clock_i) begin
        if (core_reset_i) begin
            count_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (core_flush_i) begin
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            valid_q <= issue_en;
            if (issue_en) begin
                data_q <= sel_pkt;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_ixu_sc_issue_queue.sv
// Directed testbench for ixu_sc_issue_queue with the default DEPTH of 8.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, so each sample reflects the edge that just passed.
module tb_ixu_sc_issue_queue;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          enq_valid;
    logic [5:0]    enq_rob, enq_rs1, enq_rs2;
    logic          enq_rs1_rdy, enq_rs2_rdy;
    logic          enq_ready;
    logic [5:0]    wk_dest, ext_dest;
    logic          wk_valid, ext_valid;
    logic [17:0]   data;
    logic          valid;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;
    logic [22:0] exp_v;

    ixu_sc_issue_queue #(.DEPTH(DEPTH)) dut (
        .core_clock_i       (clk),
        .core_reset_i       (rst),
        .core_flush_i       (flush),
        .enq_valid_i        (enq_valid),
        .enq_rob_i          (enq_rob),
        .enq_rs1_i          (enq_rs1),
        .enq_rs1_rdy_i      (enq_rs1_rdy),
        .enq_rs2_i          (enq_rs2),
        .enq_rs2_rdy_i      (enq_rs2_rdy),
        .enq_ready_o        (enq_ready),
        .wakeup_dest_i      (wk_dest),
        .wakeup_valid_i     (wk_valid),
        .ext_wakeup_dest_i  (ext_dest),
        .ext_wakeup_valid_i (ext_valid),
        .data_o             (data),
        .valid_o            (valid),
        .count_o            (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; enq_valid = 1'b0;
        enq_rob = '0; enq_rs1 = '0; enq_rs2 = '0; enq_rs1_rdy = 1'b0; enq_rs2_rdy = 1'b0;
        wk_dest = '0; wk_valid = 1'b0; ext_dest = '0; ext_valid = 1'b0;
    endtask

    task automatic set_enq(input logic [5:0] rob, input logic [5:0] rs1, input logic r1,
                           input logic [5:0] rs2, input logic r2);
        enq_valid = 1'b1; enq_rob = rob;
        enq_rs1 = rs1; enq_rs1_rdy = r1; enq_rs2 = rs2; enq_rs2_rdy = r2;
    endtask

    task automatic wake(input logic wv, input logic [5:0] wd, input logic ev, input logic [5:0] ed);
        wk_valid = wv; wk_dest = wd; ext_valid = ev; ext_dest = ed;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        set_enq(6'd3, 6'd0, 1'b1, 6'd0, 1'b1);
        tick(); tick();
        rst = 1'b0;
        idle();
        checks++;
        if ({valid, data, count, enq_ready} !== {1'b0, 18'h0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: got v=%b d=%h c=%0d rdy=%b, expected v=0 d=00000 c=0 rdy=1", valid, data, count, enq_ready);
        end
    endtask

    task automatic test_single_issue();
        set_enq(6'd5, 6'd3, 1'b1, 6'd0, 1'b0);
        tick();
        idle();
        exp_v = {1'b0, 18'h0, 4'd1};
        checks++;
        if ({valid, data, count} !== exp_v) begin
            errors++; $display("FAIL single_enq: got %h expected %h", {valid, data, count}, exp_v);
        end
        tick();
        exp_v = {1'b1, 18'h000C5, 4'd0};
        checks++;
        if ({valid, data, count} !== exp_v) begin
            errors++; $display("FAIL single_issue: got %h expected %h", {valid, data, count}, exp_v);
        end
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++; $display("FAIL single_pulse: got valid=%b expected 0", valid);
        end
    endtask

    task automatic test_wakeup_order();
        set_enq(6'd1, 6'd7, 1'b0, 6'd0, 1'b0);      // A waits on p7
        tick();
        set_enq(6'd2, 6'd10, 1'b1, 6'd11, 1'b1);    // B ready
        tick();
        set_enq(6'd3, 6'd8, 1'b0, 6'd0, 1'b0);      // C waits on p8, B selected this cycle
        tick();
        idle();
        exp_v = {1'b1, 6'd11, 6'd10, 6'd2, 4'd2};
        checks++;
        if ({valid, data, count} !== exp_v) begin
            errors++; $display("FAIL order_b_first: got %h expected %h", {valid, data, count}, exp_v);
        end
        wake(1'b1, 6'd7, 1'b0, 6'd0);
        tick();
        idle();
        exp_v = {1'b1, 6'd0, 6'd7, 6'd1, 4'd1};
        checks++;
        if ({valid, data, count} !== exp_v) begin
            errors++; $display("FAIL order_a_second: got %h expected %h", {valid, data, count}, exp_v);
        end
        tick();
        checks++;
        if ({valid, count} !== {1'b0, 4'd1}) begin
            errors++; $display("FAIL order_idle: got v=%b c=%0d expected v=0 c=1", valid, count);
        end
        wake(1'b0, 6'd0, 1'b1, 6'd8);
        tick();
        idle();
        exp_v = {1'b1, 6'd0, 6'd8, 6'd3, 4'd0};
        checks++;
        if ({valid, data, count} !== exp_v) begin
            errors++; $display("FAIL order_c_shifted: got %h expected %h", {valid, data, count}, exp_v);
        end
    endtask

    task automatic test_bypass();
        set_enq(6'd4, 6'd0, 1'b1, 6'd9, 1'b0);
        tick();
        idle();
        wake(1'b1, 6'd0, 1'b1, 6'd0);               // tag 0 on both ports
        tick();
        idle();
        checks++;
        if ({valid, count} !== {1'b0, 4'd1}) begin
            errors++; $display("FAIL bypass_tag0: got v=%b c=%0d expected v=0 c=1", valid, count);
        end
        wake(1'b0, 6'd0, 1'b1, 6'd9);
        tick();
        idle();
        exp_v = {1'b1, 6'd9, 6'd0, 6'd4, 4'd0};
        checks++;
        if ({valid, data, count} !== exp_v) begin
            errors++; $display("FAIL bypass_ext: got %h expected %h", {valid, data, count}, exp_v);
        end
        // Stored wakeup: p12 wakes one cycle, p13 the next.
        set_enq(6'd6, 6'd12, 1'b0, 6'd13, 1'b0);
        tick();
        idle();
        wake(1'b1, 6'd12, 1'b0, 6'd0);
        tick();
        idle();
        checks++;
        if ({valid, count} !== {1'b0, 4'd1}) begin
            errors++; $display("FAIL stored_half: got v=%b c=%0d expected v=0 c=1", valid, count);
        end
        wake(1'b0, 6'd0, 1'b1, 6'd13);
        tick();
        idle();
        exp_v = {1'b1, 6'd13, 6'd12, 6'd6, 4'd0};
        checks++;
        if ({valid, data, count} !== exp_v) begin
            errors++; $display("FAIL stored_wakeup: got %h expected %h", {valid, data, count}, exp_v);
        end
        // Enqueue-cycle wakeup is captured into the stored ready bit.
        set_enq(6'd7, 6'd14, 1'b0, 6'd0, 1'b0);
        wake(1'b1, 6'd14, 1'b0, 6'd0);
        tick();
        idle();
        tick();
        exp_v = {1'b1, 6'd0, 6'd14, 6'd7, 4'd0};
        checks++;
        if ({valid, data, count} !== exp_v) begin
            errors++; $display("FAIL enq_wakeup: got %h expected %h", {valid, data, count}, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        set_enq(6'd50, 6'd1, 1'b1, 6'd2, 1'b1);     // producer
        tick();
        set_enq(6'd51, 6'd50, 1'b0, 6'd0, 1'b0);    // consumer on p50
        tick();
        idle();
        exp_v = {1'b1, 6'd2, 6'd1, 6'd50, 4'd1};
        checks++;
        if ({valid, data, count} !== exp_v) begin
            errors++; $display("FAIL b2b_producer: got %h expected %h", {valid, data, count}, exp_v);
        end
        wake(1'b1, 6'd50, 1'b0, 6'd0);
        tick();
        idle();
        exp_v = {1'b1, 6'd0, 6'd50, 6'd51, 4'd0};
        checks++;
        if ({valid, data, count} !== exp_v) begin
            errors++; $display("FAIL b2b_consumer: got %h expected %h", {valid, data, count}, exp_v);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            set_enq(6'(10 + i), 6'(20 + i), 1'b0, 6'd0, 1'b0);
            tick();
        end
        idle();
        checks++;
        if ({count, enq_ready, valid} !== {4'd8, 1'b0, 1'b0}) begin
            errors++; $display("FAIL full_state: got c=%0d rdy=%b v=%b expected c=8 rdy=0 v=0", count, enq_ready, valid);
        end
        wake(1'b1, 6'd23, 1'b0, 6'd0);
        set_enq(6'd30, 6'd1, 1'b1, 6'd1, 1'b1);      // refused: queue full
        tick();
        idle();
        exp_v = {1'b1, 6'd0, 6'd23, 6'd13, 4'd7};
        checks++;
        if ({valid, data, count, enq_ready} !== {exp_v, 1'b1}) begin
            errors++; $display("FAIL full_refuse: got %h rdy=%b expected %h rdy=1", {valid, data, count}, enq_ready, exp_v);
        end
        tick();
        checks++;
        if ({valid, count} !== {1'b0, 4'd7}) begin
            errors++; $display("FAIL full_no_ghost: got v=%b c=%0d expected v=0 c=7", valid, count);
        end
        flush = 1'b1;
        tick();
        idle();
        checks++;
        if ({valid, count, enq_ready} !== {1'b0, 4'd0, 1'b1}) begin
            errors++; $display("FAIL full_flush: got v=%b c=%0d rdy=%b expected v=0 c=0 rdy=1", valid, count, enq_ready);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            set_enq(6'(20 + i), 6'(30 + i), 1'b0, 6'd0, 1'b0);
            tick();
        end
        idle();
        checks++;
        if (count !== 4'd4) begin
            errors++; $display("FAIL flush_fill: got c=%0d expected 4", count);
        end
        flush = 1'b1;
        wake(1'b1, 6'd31, 1'b0, 6'd0);
        set_enq(6'd24, 6'd1, 1'b1, 6'd1, 1'b1);
        tick();
        idle();
        checks++;
        if ({valid, count} !== {1'b0, 4'd0}) begin
            errors++; $display("FAIL flush_clear: got v=%b c=%0d expected v=0 c=0", valid, count);
        end
        for (int i = 0; i < 3; i++) begin
            wake(1'b1, 6'(30 + 2 * (i % 2)), 1'b1, 6'(31 + 2 * (i % 2)));
            tick();
            idle();
            checks++;
            if ({valid, count} !== {1'b0, 4'd0}) begin
                errors++; $display("FAIL flush_no_issue%0d: got v=%b c=%0d d=%h expected v=0 c=0", i, valid, count, data);
            end
        end
    endtask

    task automatic test_enq_with_issue();
        for (int i = 0; i < 3; i++) begin
            set_enq(6'(40 + i), 6'(40 + i), 1'b0, 6'd0, 1'b0);
            tick();
        end
        idle();
        wake(1'b1, 6'd41, 1'b0, 6'd0);
        set_enq(6'd9, 6'd43, 1'b0, 6'd0, 1'b0);
        tick();
        idle();
        exp_v = {1'b1, 6'd0, 6'd41, 6'd41, 4'd3};
        checks++;
        if ({valid, data, count} !== exp_v) begin
            errors++; $display("FAIL enq_issue_mid: got %h expected %h", {valid, data, count}, exp_v);
        end
        wake(1'b1, 6'd40, 1'b1, 6'd42);
        tick();
        idle();
        exp_v = {1'b1, 6'd0, 6'd40, 6'd40, 4'd2};
        checks++;
        if ({valid, data, count} !== exp_v) begin
            errors++; $display("FAIL enq_issue_old0: got %h expected %h", {valid, data, count}, exp_v);
        end
        tick();
        exp_v = {1'b1, 6'd0, 6'd42, 6'd42, 4'd1};
        checks++;
        if ({valid, data, count} !== exp_v) begin
            errors++; $display("FAIL enq_issue_old2: got %h expected %h", {valid, data, count}, exp_v);
        end
        wake(1'b1, 6'd43, 1'b0, 6'd0);
        tick();
        idle();
        exp_v = {1'b1, 6'd0, 6'd43, 6'd9, 4'd0};
        checks++;
        if ({valid, data, count} !== exp_v) begin
            errors++; $display("FAIL enq_issue_rob9: got %h expected %h", {valid, data, count}, exp_v);
        end
    endtask

    task automatic test_reset_clears_data();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({valid, data, count} !== {1'b0, 18'h0, 4'd0}) begin
            errors++; $display("FAIL reset_data: got v=%b d=%h c=%0d expected v=0 d=00000 c=0", valid, data, count);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_single_issue();
        test_wakeup_order();
        test_bypass();
        test_back_to_back();
        test_full();
        test_flush();
        test_enq_with_issue();
        test_reset_clears_data();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
